// File: rtl/rv_lsu.sv
// rv_lsu: RV32I load/store unit with tightly coupled byte-lane data RAM and a GPIO register bank.
// Optional: define RV_LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module rv_lsu #(
  parameter int DEPTH   = 1024,
  parameter int IO_BIT  = 12,
  parameter int GPIO_CH = 4,
  parameter int GPIO_W  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_funct3,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_fault,
  output logic [GPIO_CH*GPIO_W-1:0] gpio_out
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ST = 2'd1, RD = 2'd2, RESP = 2'd3} state_t;

  state_t                      state_q, state_d;
  logic [2:0]                  f3_q, f3_d;
  logic [1:0]                  off_q, off_d;
  logic [AW-1:0]               idx_q, idx_d;
  logic                        io_q, io_d;
  logic [2:0]                  ch_q, ch_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        rsp_fault_q, rsp_fault_d;
  logic [GPIO_CH*GPIO_W-1:0]   gpio_q, gpio_d;
  logic [31:0]                 ram_rdata_q;
  logic [31:0]                 mem [DEPTH];

  logic        accept;
  logic        legal;
  logic [1:0]  off_in;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] gpio_word;
  logic [31:0] load_word;
  logic        unused_addr;
`ifdef RV_LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b010:  load_ext = w;
      3'b100:  load_ext = {24'd0, b};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = 32'd0;
    endcase
  endfunction

  assign unused_addr = ^req_addr;
  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_fault   = rsp_fault_q;
  assign gpio_out    = gpio_q;

  // Request decode: legality and effective byte offset
  always_comb begin
    accept = req_valid & (state_q == IDLE);
    if (req_we) begin
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      legal = (req_funct3 != 3'b011) && (req_funct3[2:1] != 2'b11);
    end
`ifdef RV_LSU_MISALIGN_TRAP_EN
    case (req_funct3[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      default: misalign = 1'b0;
    endcase
    legal  = legal & ~misalign;
    off_in = req_addr[1:0];
`else
    case (req_funct3[1:0])
      2'b01:   off_in = {req_addr[1], 1'b0};
      2'b10:   off_in = 2'b00;
      default: off_in = req_addr[1:0];
    endcase
`endif
  end

  // Next-state, request latching, response flags and GPIO update
  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    off_d       = off_q;
    idx_d       = idx_q;
    io_d        = io_q;
    ch_d        = ch_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_fault_d = 1'b0;
    gpio_d      = gpio_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d    = req_funct3;
          off_d   = off_in;
          idx_d   = req_addr[2 +: AW];
          io_d    = req_addr[IO_BIT];
          ch_d    = req_addr[4:2];
          wdata_d = req_wdata;
          if (!legal) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
          end else if (req_we) begin
            state_d     = ST;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ST: begin
        state_d = IDLE;
        // channels >= GPIO_CH never match, so unmapped stores fall through silently
        for (int k = 0; k < GPIO_CH; k++) begin
          if (io_q && (ch_q == 3'(k))) begin
            gpio_d[k*GPIO_W +: GPIO_W] = wdata_q[GPIO_W-1:0];
          end else begin
            gpio_d[k*GPIO_W +: GPIO_W] = gpio_q[k*GPIO_W +: GPIO_W];
          end
        end
      end
      RD: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Store byte enables and lane replication; load data selection and extension
  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << off_q;
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = off_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
    endcase
    gpio_word = 32'd0;
    for (int k = 0; k < GPIO_CH; k++) begin
      gpio_word[GPIO_W-1:0] = gpio_word[GPIO_W-1:0] |
                              ((ch_q == 3'(k)) ? gpio_q[k*GPIO_W +: GPIO_W] : {GPIO_W{1'b0}});
    end
    load_word = io_q ? gpio_word : ram_rdata_q;
    if ((state_q == RESP) && !rsp_fault_q) begin
      rsp_rdata = load_ext(load_word, f3_q, off_q);
    end else begin
      rsp_rdata = 32'd0;
    end
  end

  // Control and GPIO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      idx_q       <= '0;
      io_q        <= 1'b0;
      ch_q        <= 3'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      gpio_q      <= '0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      idx_q       <= idx_d;
      io_q        <= io_d;
      ch_q        <= ch_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      gpio_q      <= gpio_d;
    end
  end

  // Data RAM: per-byte write at the end of ST, synchronous read in RD; contents survive reset
  always_ff @(posedge clk) begin
    if ((state_q == ST) && !io_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx_q][i*8 +: 8] <= wlane[i*8 +: 8];
        end
      end
    end
    if (state_q == RD) begin
      ram_rdata_q <= mem[idx_q];
    end
  end
endmodule

// File: tb/tb_rv_lsu.sv
// Directed self-checking bench for rv_lsu (default parameters: DEPTH 1024, IO_BIT 12, 4 x 3-bit GPIO).
module tb_rv_lsu;
  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [11:0] gpio_out;

  int vectors;
  int miscompares;
  int cyc;
  int lat, acc, acc0;
  logic [31:0] rd;
  logic flt, rb;

  rv_lsu dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .gpio_out(gpio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one request, scrambles the inputs after acceptance, and reports what came back.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int l, output logic [31:0] r,
                        output logic f, output int ac, output logic busy_rdy);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1;
    ac = cyc;
    busy_rdy = req_ready;
    req_valid = 1'b0; req_we = ~we; req_funct3 = ~f3; req_addr = ~a; req_wdata = ~d;
    l = 1;
    while (rsp_valid !== 1'b1 && l < 6) begin
      @(posedge clk);
      #1;
      l++;
    end
    r = rsp_rdata;
    f = rsp_fault;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    vectors++; if (rsp_fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b want 0", rsp_fault); end
    vectors++; if (rsp_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    vectors++; if (gpio_out !== 12'd0) begin miscompares++; $display("FAIL reset_gpio got %h want 0", gpio_out); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_word();
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, flt, acc, rb);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL sw_latency got %0d want 1", lat); end
    vectors++; if (flt !== 1'b0) begin miscompares++; $display("FAIL sw_fault got %b want 0", flt); end
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL sw_rdata got %h want 0", rd); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL sw_pulse got %b want 0", rsp_valid); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL lw_latency got %0d want 2", lat); end
    vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_data got %h want deadbeef", rd); end
    vectors++; if (flt !== 1'b0) begin miscompares++; $display("FAIL lw_fault got %b want 0", flt); end
    vectors++; if (rb !== 1'b0) begin miscompares++; $display("FAIL busy_ready got %b want 0", rb); end
  endtask

  task automatic test_bytes();
    do_req(1'b1, 3'b000, 32'h11, 32'h12345680, lat, rd, flt, acc, rb);
    do_req(1'b0, 3'b000, 32'h11, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (rd !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_data got %h want ffffff80", rd); end
    do_req(1'b0, 3'b100, 32'h11, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (rd !== 32'h00000080) begin miscompares++; $display("FAIL lbu_data got %h want 00000080", rd); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (rd !== 32'hDEAD80EF) begin miscompares++; $display("FAIL sb_lanes got %h want dead80ef", rd); end
  endtask

  task automatic test_half();
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, flt, acc, rb);
    do_req(1'b1, 3'b001, 32'h12, 32'hABCD1234, lat, rd, flt, acc, rb);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (rd !== 32'h00001234) begin miscompares++; $display("FAIL lh_data got %h want 00001234", rd); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (rd !== 32'h1234BEEF) begin miscompares++; $display("FAIL sh_lanes got %h want 1234beef", rd); end
    do_req(1'b1, 3'b001, 32'h16, 32'hFFFF8001, lat, rd, flt, acc, rb);
    do_req(1'b0, 3'b001, 32'h16, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (rd !== 32'hFFFF8001) begin miscompares++; $display("FAIL lh_sext got %h want ffff8001", rd); end
    do_req(1'b0, 3'b101, 32'h16, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (rd !== 32'h00008001) begin miscompares++; $display("FAIL lhu_zext got %h want 00008001", rd); end
  endtask

  task automatic test_gpio();
    do_req(1'b1, 3'b010, 32'h1004, 32'h5, lat, rd, flt, acc, rb);
    vectors++; if (gpio_out !== 12'h028) begin miscompares++; $display("FAIL gpio_ch1 got %h want 028", gpio_out); end
    do_req(1'b1, 3'b010, 32'h101C, 32'h7, lat, rd, flt, acc, rb);
    vectors++; if (flt !== 1'b0) begin miscompares++; $display("FAIL gpio_unmapped_fault got %b want 0", flt); end
    vectors++; if (gpio_out !== 12'h028) begin miscompares++; $display("FAIL gpio_unmapped got %h want 028", gpio_out); end
    do_req(1'b0, 3'b010, 32'h1004, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (rd !== 32'h5) begin miscompares++; $display("FAIL gpio_read got %h want 5", rd); end
    do_req(1'b0, 3'b010, 32'h101C, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL gpio_unmapped_read got %h want 0", rd); end
    do_req(1'b1, 3'b000, 32'h1000, 32'hFFFFFFFF, lat, rd, flt, acc, rb);
    vectors++; if (gpio_out !== 12'h02F) begin miscompares++; $display("FAIL gpio_ch0 got %h want 02f", gpio_out); end
    do_req(1'b0, 3'b000, 32'h1000, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (rd !== 32'h7) begin miscompares++; $display("FAIL gpio_lb got %h want 7", rd); end
  endtask

  task automatic test_illegal();
    do_req(1'b0, 3'b011, 32'h10, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (flt !== 1'b1) begin miscompares++; $display("FAIL ill_load_fault got %b want 1", flt); end
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL ill_load_rdata got %h want 0", rd); end
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL ill_load_latency got %0d want 1", lat); end
    do_req(1'b1, 3'b100, 32'h10, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (flt !== 1'b1) begin miscompares++; $display("FAIL ill_store_fault got %b want 1", flt); end
    do_req(1'b1, 3'b101, 32'h1004, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (flt !== 1'b1) begin miscompares++; $display("FAIL ill_gpio_fault got %b want 1", flt); end
    vectors++; if (gpio_out !== 12'h02F) begin miscompares++; $display("FAIL ill_gpio_kept got %h want 02f", gpio_out); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (rd !== 32'h1234BEEF) begin miscompares++; $display("FAIL ill_ram_kept got %h want 1234beef", rd); end
  endtask

  task automatic test_misalign();
    do_req(1'b0, 3'b010, 32'h12, 32'h0, lat, rd, flt, acc, rb);
`ifdef RV_LSU_MISALIGN_TRAP_EN
    vectors++; if (flt !== 1'b1) begin miscompares++; $display("FAIL mis_lw_fault got %b want 1", flt); end
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL mis_lw_rdata got %h want 0", rd); end
    do_req(1'b0, 3'b001, 32'h13, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (flt !== 1'b1) begin miscompares++; $display("FAIL mis_lh_fault got %b want 1", flt); end
`else
    vectors++; if (flt !== 1'b0) begin miscompares++; $display("FAIL mis_lw_fault got %b want 0", flt); end
    vectors++; if (rd !== 32'h1234BEEF) begin miscompares++; $display("FAIL mis_lw_align got %h want 1234beef", rd); end
    do_req(1'b0, 3'b001, 32'h13, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (rd !== 32'h00001234) begin miscompares++; $display("FAIL mis_lh_align got %h want 00001234", rd); end
`endif
  endtask

  task automatic test_reset_midstore();
    do_req(1'b1, 3'b010, 32'h20, 32'h11112222, lat, rd, flt, acc, rb);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL mid_st_valid got %b want 1", rsp_valid); end
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b want 0", rsp_valid); end
    vectors++; if (gpio_out !== 12'd0) begin miscompares++; $display("FAIL mid_rst_gpio got %h want 0", gpio_out); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready got %b want 1", req_ready); end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (rd !== 32'h11112222) begin miscompares++; $display("FAIL mid_rst_nowrite got %h want 11112222", rd); end
    do_req(1'b1, 3'b010, 32'h2000, 32'h0BADF00D, lat, rd, flt, acc, rb);
    do_req(1'b0, 3'b010, 32'h0, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (rd !== 32'h0BADF00D) begin miscompares++; $display("FAIL alias_word0 got %h want 0badf00d", rd); end
    vectors++; if (gpio_out !== 12'd0) begin miscompares++; $display("FAIL alias_gpio got %h want 0", gpio_out); end
  endtask

  task automatic test_back_to_back();
    do_req(1'b1, 3'b010, 32'h30, 32'h1, lat, rd, flt, acc0, rb);
    do_req(1'b1, 3'b010, 32'h34, 32'h2, lat, rd, flt, acc, rb);
    vectors++; if (acc - acc0 !== 2) begin miscompares++; $display("FAIL b2b_store got %0d want 2", acc - acc0); end
    do_req(1'b0, 3'b010, 32'h30, 32'h0, lat, rd, flt, acc0, rb);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL b2b_ld0 got %h want 1", rd); end
    do_req(1'b0, 3'b010, 32'h34, 32'h0, lat, rd, flt, acc, rb);
    vectors++; if (acc - acc0 !== 3) begin miscompares++; $display("FAIL b2b_load got %0d want 3", acc - acc0); end
    vectors++; if (rd !== 32'h2) begin miscompares++; $display("FAIL b2b_ld1 got %h want 2", rd); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    test_reset();
    test_word();
    test_bytes();
    test_half();
    test_gpio();
    test_illegal();
    test_misalign();
    test_reset_midstore();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
